// File: rtl/cellrv32_cpu_rf_wb_sequencer_pkg.sv
// Shared CPU definitions for the register-file write-back path:
// the buffered write-back entry, source indices and address masking.
package cellrv32_cpu_rf_wb_sequencer_pkg;

  localparam int cpu_xlen_c = 32;

  localparam int wb_src_num_c = 3;
  localparam int wb_src_alu_c = 0;
  localparam int wb_src_mem_c = 1;
  localparam int wb_src_cp_c  = 2;

  typedef struct packed {
    logic [4:0]            rd;
    logic [cpu_xlen_c-1:0] data;
  } wb_entry_t;

  // RV32E has only x0..x15, so bit 4 of every register address is forced low
  function automatic logic [4:0] reg_addr_mask(input logic [4:0] addr, input logic rv32e);
    return rv32e ? {1'b0, addr[3:0]} : addr;
  endfunction

endpackage

// File: rtl/cellrv32_cpu_wb_fifo.sv
// Synchronous write-back FIFO: power-of-two depth, wrapping pointers,
// separately tracked occupancy and a synchronous clear that beats push/pop.
module cellrv32_cpu_wb_fifo
  import cellrv32_cpu_rf_wb_sequencer_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                   clk_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  entry_t                 wdata_i,
  input  logic                   pop_i,
  output entry_t                 rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  entry_t        mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [LW-1:0] level_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (level_r == LW'(DEPTH));
  assign empty_o   = (level_r == LW'(0));
  assign do_push_s = push_i & ~full_o & ~clr_i;
  assign do_pop_s  = pop_i & ~empty_o & ~clr_i;
  assign rdata_o   = mem_r[rptr_r];
  assign level_o   = level_r;

  // entry storage, written at the tail
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_r[wptr_r] <= wdata_i;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      wptr_r  <= AW'(0);
      rptr_r  <= AW'(0);
      level_r <= LW'(0);
    end else begin
      if (do_push_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/cellrv32_cpu_rf_wb_sequencer.sv
// Write-back sequencer: arbitrates producer results into a FIFO, drains one
// write per cycle into the register file and tracks pending destinations.
module cellrv32_cpu_rf_wb_sequencer
  import cellrv32_cpu_rf_wb_sequencer_pkg::*;
#(
  parameter int XLEN                  = 32,
  parameter int FIFO_DEPTH            = 4,
  parameter int CPU_EXTENSION_RISCV_E = 0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic [wb_src_num_c-1:0]              req_valid_i,
  input  logic [wb_src_num_c-1:0][4:0]         req_rd_i,
  input  logic [wb_src_num_c-1:0][XLEN-1:0]    req_data_i,
  output logic [wb_src_num_c-1:0]              req_ready_o,
  input  logic                                 wb_stall_i,
  output logic                                 wb_en_o,
  output logic [4:0]                           wb_rd_o,
  output logic [XLEN-1:0]                      wb_data_o,
  input  logic                                 claim_i,
  input  logic [4:0]                           claim_rd_i,
  input  logic [4:0]                           rs1_i,
  input  logic [4:0]                           rs2_i,
  input  logic                                 rs1_en_i,
  input  logic                                 rs2_en_i,
  output logic                                 hazard_o,
  output logic [$clog2(FIFO_DEPTH):0]          level_o
);

  localparam logic RV32E = (CPU_EXTENSION_RISCV_E != 0);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  logic                    clr_s;
  logic [wb_src_num_c-1:0] grant_s;
  logic [4:0]              sel_rd_s;
  logic [XLEN-1:0]         sel_data_s;
  logic [4:0]              sel_rd_m_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    full_s;
  logic                    empty_s;
  entry_t                  push_entry_s;
  entry_t                  head_s;
  logic                    wb_en_r;
  logic [4:0]              wb_rd_r;
  logic [XLEN-1:0]         wb_data_r;
  logic [31:0]             pending_r;
  logic [31:0]             pending_nxt_s;
  logic [4:0]              claim_rd_m_s;
  logic [4:0]              rs1_m_s;
  logic [4:0]              rs2_m_s;

  assign clr_s = rst_i | flush_i;

  // fixed-priority arbiter: lowest-indexed valid producer wins
  always_comb begin
    grant_s    = '0;
    sel_rd_s   = 5'd0;
    sel_data_s = '0;
    if (req_valid_i[wb_src_alu_c]) begin
      grant_s[wb_src_alu_c] = 1'b1;
      sel_rd_s              = req_rd_i[wb_src_alu_c];
      sel_data_s            = req_data_i[wb_src_alu_c];
    end else if (req_valid_i[wb_src_mem_c]) begin
      grant_s[wb_src_mem_c] = 1'b1;
      sel_rd_s              = req_rd_i[wb_src_mem_c];
      sel_data_s            = req_data_i[wb_src_mem_c];
    end else if (req_valid_i[wb_src_cp_c]) begin
      grant_s[wb_src_cp_c] = 1'b1;
      sel_rd_s             = req_rd_i[wb_src_cp_c];
      sel_data_s           = req_data_i[wb_src_cp_c];
    end else begin
      grant_s = '0;
    end
  end

  // a pop in the same cycle never frees a slot for a push
  assign req_ready_o = full_s ? '0 : grant_s;

  assign sel_rd_m_s        = reg_addr_mask(sel_rd_s, RV32E);
  assign push_entry_s.rd   = sel_rd_m_s;
  assign push_entry_s.data = sel_data_s;

  // x0 writes are acknowledged but never buffered
  assign push_s = (|(req_valid_i & req_ready_o)) & (sel_rd_m_s != 5'd0) & ~clr_s;
  assign pop_s  = ~empty_s & ~wb_stall_i & ~clr_s;

  cellrv32_cpu_wb_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_wb_fifo (
    .clk_i   (clk_i),
    .clr_i   (clr_s),
    .push_i  (push_s),
    .wdata_i (push_entry_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .level_o (level_o),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // register-file write port; address/data hold while idle
  always_ff @(posedge clk_i) begin
    if (clr_s) begin
      wb_en_r   <= 1'b0;
      wb_rd_r   <= 5'd0;
      wb_data_r <= '0;
    end else if (pop_s) begin
      wb_en_r   <= 1'b1;
      wb_rd_r   <= head_s.rd;
      wb_data_r <= head_s.data;
    end else begin
      wb_en_r   <= 1'b0;
    end
  end

  assign wb_en_o   = wb_en_r;
  assign wb_rd_o   = wb_rd_r;
  assign wb_data_o = wb_data_r;

  assign claim_rd_m_s = reg_addr_mask(claim_rd_i, RV32E);
  assign rs1_m_s      = reg_addr_mask(rs1_i, RV32E);
  assign rs2_m_s      = reg_addr_mask(rs2_i, RV32E);

  // pending scoreboard: clear on retirement first so a same-index claim wins
  always_comb begin
    pending_nxt_s                = pending_r;
    pending_nxt_s[wb_rd_r]       = pending_r[wb_rd_r] & ~wb_en_r;
    pending_nxt_s[claim_rd_m_s]  = pending_nxt_s[claim_rd_m_s] |
                                   (claim_i & (claim_rd_m_s != 5'd0));
    pending_nxt_s[0]             = 1'b0;
  end

  // scoreboard state
  always_ff @(posedge clk_i) begin
    if (clr_s) begin
      pending_r <= 32'd0;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  assign hazard_o = (rs1_en_i & pending_r[rs1_m_s]) | (rs2_en_i & pending_r[rs2_m_s]);

endmodule
